// File: rtl/fire_control.sv
// fire_control: resolves one-hot keypad shots against the ship map and tracks hit/miss state
// Revision 1.0
`default_nettype none

module fire_control #(
   parameter int CELLS     = 36,
   parameter int MAX_SHOTS = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             new_game,
   input  logic             fire,
   input  logic [CELLS-1:0] pressed_key,
   input  logic [CELLS-1:0] ships,
   output logic             busy,
   output logic             result_valid,
   output logic             result_hit,
   output logic             result_repeat,
   output logic             result_invalid,
   output logic [CELLS-1:0] hit_map,
   output logic [CELLS-1:0] miss_map,
   output logic [5:0]       shot_count,
   output logic [5:0]       hit_count,
   output logic             game_over,
   output logic             win
);

   localparam int         IDX_W       = $clog2(CELLS);
   localparam logic [5:0] c_CELLS_CNT = 6'(CELLS);
   localparam logic [5:0] c_MAX_SHOTS = 6'(MAX_SHOTS);
   localparam logic [CELLS-1:0] c_ONE = CELLS'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      RESULT = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_q;
   logic [CELLS-1:0] key_q;
   logic [CELLS-1:0] hit_map_q, hit_map_d;
   logic [CELLS-1:0] miss_map_q, miss_map_d;
   logic [5:0]       shot_count_q, shot_count_d;
   logic [5:0]       hit_count_q, hit_count_d;
   logic             result_hit_q, result_hit_d;
   logic             result_repeat_q, result_repeat_d;
   logic             result_invalid_q, result_invalid_d;
   logic             result_valid_q;
   logic             busy_q;
   logic             game_over_q;
   logic             win_q;

   logic [IDX_W-1:0] w_idx;
   logic             w_onehot;
   logic             w_win;
   logic             w_loss;

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < CELLS; i++) begin
         if (key_q[i]) w_idx = IDX_W'(i);
      end
      w_onehot = (key_q != '0) && ((key_q & (key_q - c_ONE)) == '0);
   end

   // Classification order matters: invalid beats repeat beats hit/miss.
   always_comb begin
      hit_map_d        = hit_map_q;
      miss_map_d       = miss_map_q;
      shot_count_d     = shot_count_q;
      hit_count_d      = hit_count_q;
      result_hit_d     = 1'b0;
      result_repeat_d  = 1'b0;
      result_invalid_d = 1'b0;
      if (!w_onehot) begin
         result_invalid_d = 1'b1;
      end else if (hit_map_q[w_idx] || miss_map_q[w_idx]) begin
         result_repeat_d = 1'b1;
      end else begin
         if (ships[w_idx]) begin
            result_hit_d     = 1'b1;
            hit_map_d[w_idx] = 1'b1;
            if (hit_count_q < c_CELLS_CNT) hit_count_d = hit_count_q + 6'd1;
         end else begin
            miss_map_d[w_idx] = 1'b1;
         end
         if (shot_count_q < c_MAX_SHOTS) shot_count_d = shot_count_q + 6'd1;
      end
   end

   assign w_win  = (ships != '0) && (hit_map_q == ships);
   assign w_loss = (shot_count_q == c_MAX_SHOTS);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         key_q            <= '0;
         hit_map_q        <= '0;
         miss_map_q       <= '0;
         shot_count_q     <= '0;
         hit_count_q      <= '0;
         result_hit_q     <= 1'b0;
         result_repeat_q  <= 1'b0;
         result_invalid_q <= 1'b0;
         result_valid_q   <= 1'b0;
         busy_q           <= 1'b0;
         game_over_q      <= 1'b0;
         win_q            <= 1'b0;
      end else if (new_game) begin
         state_q          <= IDLE;
         key_q            <= '0;
         hit_map_q        <= '0;
         miss_map_q       <= '0;
         shot_count_q     <= '0;
         hit_count_q      <= '0;
         result_hit_q     <= 1'b0;
         result_repeat_q  <= 1'b0;
         result_invalid_q <= 1'b0;
         result_valid_q   <= 1'b0;
         busy_q           <= 1'b0;
         game_over_q      <= 1'b0;
         win_q            <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (fire) begin
                  key_q   <= pressed_key;
                  state_q <= EVAL;
                  busy_q  <= 1'b1;
               end
            end
            EVAL: begin
               hit_map_q        <= hit_map_d;
               miss_map_q       <= miss_map_d;
               shot_count_q     <= shot_count_d;
               hit_count_q      <= hit_count_d;
               result_hit_q     <= result_hit_d;
               result_repeat_q  <= result_repeat_d;
               result_invalid_q <= result_invalid_d;
               state_q          <= RESULT;
            end
            RESULT: begin
               result_valid_q <= 1'b1;
               // Win is checked first so a winning final shot is never scored as a loss.
               if (w_win) begin
                  state_q     <= DONE;
                  game_over_q <= 1'b1;
                  win_q       <= 1'b1;
               end else if (w_loss) begin
                  state_q     <= DONE;
                  game_over_q <= 1'b1;
                  win_q       <= 1'b0;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            DONE: begin
               busy_q      <= 1'b1;
               game_over_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign result_valid   = result_valid_q;
   assign result_hit     = result_hit_q;
   assign result_repeat  = result_repeat_q;
   assign result_invalid = result_invalid_q;
   assign hit_map        = hit_map_q;
   assign miss_map       = miss_map_q;
   assign shot_count     = shot_count_q;
   assign hit_count      = hit_count_q;
   assign game_over      = game_over_q;
   assign win            = win_q;

endmodule

`default_nettype wire

// File: tb/tb_fire_control.sv
// tb_fire_control: directed self-checking bench for fire_control
// Revision 1.0
`default_nettype none

module tb_fire_control;

   logic        clk = 1'b0;
   logic        reset;
   logic        new_game;
   logic        fire;
   logic [35:0] pressed_key;
   logic [35:0] ships;
   logic        busy;
   logic        result_valid;
   logic        result_hit;
   logic        result_repeat;
   logic        result_invalid;
   logic [35:0] hit_map;
   logic [35:0] miss_map;
   logic [5:0]  shot_count;
   logic [5:0]  hit_count;
   logic        game_over;
   logic        win;

   int checks = 0;
   int errors = 0;

   fire_control #(.CELLS(36), .MAX_SHOTS(20)) dut (
      .clk            (clk),
      .reset          (reset),
      .new_game       (new_game),
      .fire           (fire),
      .pressed_key    (pressed_key),
      .ships          (ships),
      .busy           (busy),
      .result_valid   (result_valid),
      .result_hit     (result_hit),
      .result_repeat  (result_repeat),
      .result_invalid (result_invalid),
      .hit_map        (hit_map),
      .miss_map       (miss_map),
      .shot_count     (shot_count),
      .hit_count      (hit_count),
      .game_over      (game_over),
      .win            (win)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Fires one key; lat = posedges after the fire edge until result_valid, 0 if none within 6.
   task automatic do_fire(input logic [35:0] key, output int lat);
      @(negedge clk);
      fire = 1'b1;
      pressed_key = key;
      @(posedge clk);
      @(negedge clk);
      fire = 1'b0;
      lat = 0;
      for (int i = 1; i <= 6 && lat == 0; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (result_valid) lat = i;
      end
   endtask

   task automatic pulse_new_game();
      @(negedge clk);
      new_game = 1'b1;
      @(posedge clk);
      @(negedge clk);
      new_game = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if ({busy, result_valid, game_over, win, result_hit, result_repeat, result_invalid} !== 7'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0", {busy, result_valid, game_over, win, result_hit, result_repeat, result_invalid}); end
      checks++; if ({hit_map, miss_map, shot_count, hit_count} !== 84'h0) begin errors++; $display("FAIL reset_maps: got %h expected 0", {hit_map, miss_map, shot_count, hit_count}); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({busy, result_valid, game_over} !== 3'b000) begin errors++; $display("FAIL reset_release_idle: got %b expected 000", {busy, result_valid, game_over}); end
   endtask

   task automatic test_hit_repeat_miss();
      int lat;
      ships = 36'h000000007;
      pulse_new_game();
      do_fire(36'h1, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL hit_latency: got %0d expected 2", lat); end
      checks++; if ({result_hit, result_repeat, result_invalid} !== 3'b100) begin errors++; $display("FAIL hit_flags: got %b expected 100", {result_hit, result_repeat, result_invalid}); end
      checks++; if (hit_map !== 36'h1) begin errors++; $display("FAIL hit_map: got %h expected 1", hit_map); end
      checks++; if ({hit_count, shot_count} !== {6'd1, 6'd1}) begin errors++; $display("FAIL hit_counts: got %0d/%0d expected 1/1", hit_count, shot_count); end
      @(negedge clk);
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got %b expected 0", result_valid); end
      do_fire(36'h1, lat);
      checks++; if ({lat[3:0], result_hit, result_repeat, result_invalid} !== {4'd2, 3'b010}) begin errors++; $display("FAIL repeat_flags: got lat %0d flags %b expected 2 010", lat, {result_hit, result_repeat, result_invalid}); end
      checks++; if ({hit_count, shot_count} !== {6'd1, 6'd1}) begin errors++; $display("FAIL repeat_counts: got %0d/%0d expected 1/1", hit_count, shot_count); end
      do_fire(36'h8, lat);
      checks++; if ({result_hit, result_repeat, result_invalid} !== 3'b000) begin errors++; $display("FAIL miss_flags: got %b expected 000", {result_hit, result_repeat, result_invalid}); end
      checks++; if (miss_map !== 36'h8) begin errors++; $display("FAIL miss_map: got %h expected 8", miss_map); end
      checks++; if ({hit_count, shot_count} !== {6'd1, 6'd2}) begin errors++; $display("FAIL miss_counts: got %0d/%0d expected 1/2", hit_count, shot_count); end
   endtask

   task automatic test_invalid();
      int lat;
      do_fire(36'h3, lat);
      checks++; if ({lat[3:0], result_hit, result_repeat, result_invalid} !== {4'd2, 3'b001}) begin errors++; $display("FAIL invalid_multi: got lat %0d flags %b expected 2 001", lat, {result_hit, result_repeat, result_invalid}); end
      do_fire(36'h0, lat);
      checks++; if ({lat[3:0], result_hit, result_repeat, result_invalid} !== {4'd2, 3'b001}) begin errors++; $display("FAIL invalid_zero: got lat %0d flags %b expected 2 001", lat, {result_hit, result_repeat, result_invalid}); end
      checks++; if ({hit_map, miss_map, hit_count, shot_count} !== {36'h1, 36'h8, 6'd1, 6'd2}) begin errors++; $display("FAIL invalid_state: got %h %h %0d %0d expected 1 8 1 2", hit_map, miss_map, hit_count, shot_count); end
   endtask

   task automatic test_win();
      int lat;
      ships = 36'h000000007;
      pulse_new_game();
      checks++; if ({hit_map, miss_map, shot_count} !== 78'h0) begin errors++; $display("FAIL new_game_clear: got %h expected 0", {hit_map, miss_map, shot_count}); end
      do_fire(36'h1, lat);
      do_fire(36'h2, lat);
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL win_early: got %b expected 0", game_over); end
      do_fire(36'h4, lat);
      checks++; if ({lat[3:0], game_over, win, busy} !== {4'd2, 3'b111}) begin errors++; $display("FAIL win_done: got lat %0d go/win/busy %b expected 2 111", lat, {game_over, win, busy}); end
      checks++; if (hit_count !== 6'd3) begin errors++; $display("FAIL win_hit_count: got %0d expected 3", hit_count); end
      do_fire(36'h8, lat);
      checks++; if (lat !== 0) begin errors++; $display("FAIL done_ignores_fire: got valid at %0d expected none", lat); end
      checks++; if ({shot_count, miss_map} !== {6'd3, 36'h0}) begin errors++; $display("FAIL done_state_frozen: got %0d %h expected 3 0", shot_count, miss_map); end
      pulse_new_game();
      checks++; if ({game_over, win, busy, hit_map} !== {3'b000, 36'h0}) begin errors++; $display("FAIL new_game_done: got %b %h expected 000 0", {game_over, win, busy}, hit_map); end
   endtask

   task automatic test_loss(input logic last_is_ship);
      int lat;
      logic [35:0] k;
      ships = 36'h800000000;
      pulse_new_game();
      for (int i = 0; i < 20; i++) begin
         k = '0;
         if (i == 19 && last_is_ship) k[35] = 1'b1;
         else k[i] = 1'b1;
         do_fire(k, lat);
         checks++; if (lat !== 2) begin errors++; $display("FAIL loss_shot_%0d_latency: got %0d expected 2", i, lat); end
         if (i == 18) begin
            checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL loss_early: got %b expected 0", game_over); end
         end
      end
      checks++; if ({game_over, win} !== {1'b1, last_is_ship}) begin errors++; $display("FAIL loss_end: got go/win %b expected 1%b", {game_over, win}, last_is_ship); end
      checks++; if (shot_count !== 6'd20) begin errors++; $display("FAIL loss_shot_count: got %0d expected 20", shot_count); end
      checks++; if (hit_count !== {5'd0, last_is_ship}) begin errors++; $display("FAIL loss_hit_count: got %0d expected %0d", hit_count, last_is_ship); end
   endtask

   task automatic test_busy_drop();
      int cnt;
      ships = 36'h000000007;
      pulse_new_game();
      cnt = 0;
      @(negedge clk);
      fire = 1'b1;
      pressed_key = 36'h1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         if (result_valid) cnt++;
      end
      fire = 1'b0;
      repeat (6) begin
         @(posedge clk);
         @(negedge clk);
         if (result_valid) cnt++;
      end
      checks++; if (cnt !== 1) begin errors++; $display("FAIL busy_drop_pulses: got %0d expected 1", cnt); end
      checks++; if (shot_count !== 6'd1) begin errors++; $display("FAIL busy_drop_count: got %0d expected 1", shot_count); end
   endtask

   task automatic test_async_reset();
      int cnt;
      ships = 36'h000000007;
      pulse_new_game();
      @(negedge clk);
      fire = 1'b1;
      pressed_key = 36'h2;
      @(posedge clk);
      #2;
      fire = 1'b0;
      reset = 1'b0;
      #1;
      checks++; if ({busy, result_valid, game_over, win, hit_map, shot_count} !== 46'h0) begin errors++; $display("FAIL async_reset_mid_eval: got %h expected 0", {busy, result_valid, game_over, win, hit_map, shot_count}); end
      @(negedge clk);
      reset = 1'b1;
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (result_valid) cnt++;
      end
      checks++; if ({cnt[3:0], hit_map, shot_count} !== {4'd0, 36'h0, 6'd0}) begin errors++; $display("FAIL async_reset_no_result: got %0d %h %0d expected 0 0 0", cnt, hit_map, shot_count); end
   endtask

   task automatic test_new_game_mid();
      int cnt;
      ships = 36'h000000007;
      @(negedge clk);
      fire = 1'b1;
      pressed_key = 36'h1;
      @(posedge clk);
      @(negedge clk);
      fire = 1'b0;
      new_game = 1'b1;
      @(posedge clk);
      @(negedge clk);
      new_game = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL new_game_mid_busy: got %b expected 0", busy); end
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (result_valid) cnt++;
      end
      checks++; if ({cnt[3:0], hit_map, shot_count} !== {4'd0, 36'h0, 6'd0}) begin errors++; $display("FAIL new_game_mid_no_result: got %0d %h %0d expected 0 0 0", cnt, hit_map, shot_count); end
   endtask

   initial begin
      reset = 1'b0;
      new_game = 1'b0;
      fire = 1'b0;
      pressed_key = '0;
      ships = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_hit_repeat_miss();
      test_invalid();
      test_win();
      test_loss(1'b0);
      test_loss(1'b1);
      test_busy_drop();
      test_async_reset();
      test_new_game_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
